// File: rtl/adder_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_chk_pkg
//  Description : Shared types for the 4-bit adder result checker: run-state
//                encoding, the observed-transaction record and the result
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_chk_pkg;

    // Operand width of the adder under check; results carry one extra bit.
    localparam int c_W     = 4;
    localparam int c_RES_W = c_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // Field order {a, b, y} is also the bit layout reported in first_fail.
    typedef struct packed {
        logic [c_W-1:0]     a;
        logic [c_W-1:0]     b;
        logic [c_RES_W-1:0] y;
    } txn_t;

endpackage
`default_nettype wire

// File: rtl/chk_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : chk_skid_fifo
//  Description : Circular skid buffer carrying observed adder transactions.
//                Pointers carry one extra wrap bit so full and empty are
//                distinguished without a separate count.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                i_push, i_din   - write strobe and transaction to store
//                i_pop, o_dout   - read strobe and head-of-queue transaction
//                o_full, o_empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module chk_skid_fifo
    import adder_chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  txn_t i_din,
    input  logic i_pop,
    output txn_t o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    txn_t          r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : adder_result_checker
//  Description : Response-side checker for the adder datapath. Accepts
//                observed (a, b, y) transactions over valid/ready, recomputes
//                a + b through a two-stage pipeline, counts passes/failures
//                and latches the first failing transaction.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                start, num_txn    - arm a run of num_txn transactions
//                in_valid/in_ready - observed-transaction handshake
//                in_a, in_b, in_y  - observed operands and adder result
//                busy, done, err   - run status, sticky mismatch flag
//                pass_cnt/fail_cnt - saturating per-run counters
//                first_fail        - {a, b, y} of the first mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int W          = 4,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3*W:0]     first_fail
);

    chk_state_t         r_state;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [CNT_W-1:0]   r_pass;
    logic [CNT_W-1:0]   r_fail;
    txn_t               r_first_fail;

    logic               r_s1_valid;
    txn_t               r_s1_txn;
    logic [c_RES_W-1:0] r_s1_exp;
    logic               r_s2_valid;

    txn_t               w_in_txn;
    txn_t               w_fifo_dout;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_last;
    logic               w_match;

    assign w_in_txn = '{a: in_a, b: in_b, y: in_y};

    // The comparison stage never stalls, so S1 always advances and the
    // FIFO drains whenever it holds something.
    assign w_pop      = !w_empty;
    assign w_in_ready = (r_state == RUN) && (!w_full || w_pop);
    assign w_push     = in_valid && w_in_ready;
    // r_acc < r_num throughout RUN, so the increment cannot overflow here.
    assign w_last     = ((r_acc + 1'b1) == r_num);
    assign w_match    = (r_s1_txn.y == r_s1_exp);

    chk_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_in_txn),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // S1: capture the transaction and its zero-extended expected sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_pop;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_s1_txn <= w_fifo_dout;
            r_s1_exp <= c_RES_W'(w_fifo_dout.a) + c_RES_W'(w_fifo_dout.b);
        end
    end

    // Run control plus S2 compare/count. A start clears the counters in the
    // same edge; the pipeline is always empty in IDLE/DONE so no S2 update
    // can collide with that clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_num        <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_first_fail <= '0;
        end else begin
            if (r_s1_valid) begin
                if (w_match) begin
                    if (r_pass != '1) begin
                        r_pass <= r_pass + 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                    if (r_fail == '0) begin
                        r_first_fail <= r_s1_txn;
                    end
                    if (r_fail != '1) begin
                        r_fail <= r_fail + 1'b1;
                    end
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_pass       <= '0;
                        r_fail       <= '0;
                        r_err        <= 1'b0;
                        r_first_fail <= '0;
                        r_num        <= num_txn;
                        r_acc        <= '0;
                        if (num_txn == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_acc <= r_acc + 1'b1;
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty && !r_s1_valid && !r_s2_valid) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Synthesizable response-side checker for the 4-bit adder datapath; it is the consumer end of the stimulus stream that drives the adder.
- Accepts observed transactions (a, b, y) over a valid/ready handshake and recomputes the expected sum through a 2-stage pipeline.
- Counts passes and failures, and latches the first failing transaction.
- Runs for a programmed number of transactions, then reports done. Used as an on-chip self-check beside the adder and as a bind target in simulation.

Parameters:
- W, 4, operand width; result width is W+1.
- CNT_W, 8, width of the transaction, pass and fail counters.
- FIFO_DEPTH, 4, input skid buffer depth (power of two, >= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; arms a run of num_txn transactions.
- num_txn  in  CNT_W  transactions to check per run; sampled on start.
- in_valid  in  1  observed transaction valid.
- in_ready  out  1  checker can accept.
- in_a  in  W  observed operand a.
- in_b  in  W  observed operand b.
- in_y  in  W+1  observed adder result.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- err  out  1  sticky; at least one mismatch this run.
- pass_cnt  out  CNT_W  matching transactions this run.
- fail_cnt  out  CNT_W  mismatching transactions this run.
- first_fail  out  3W+1  {a, b, y} of the first mismatch; zero if none.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low: clk, rst_n.
  - On rst_n=0 at a clk edge, all state clears: busy=0, done=0, err=0, counters=0, first_fail=0, in_ready=0, FIFO empty, pipeline valids=0.
  - Reset mid-run abandons the run; no partial results persist.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: in_ready=0. start moves to RUN, clears the counters, err and first_fail, and latches num_txn.
  - start with num_txn=0 goes directly to DONE the next cycle, with zero counts.
  - RUN: in_ready = !fifo_full. A transfer occurs when in_valid && in_ready. Accepted transactions are counted.
  - When the accepted count equals the latched num_txn, move to DRAIN. in_ready drops the same cycle the last transfer is seen, so no extra transfer occurs.
  - DRAIN: in_ready=0. Wait until the FIFO and both pipeline stages are empty, then go to DONE.
  - DONE: done=1, busy=0. start restarts as from IDLE; counters clear the cycle start is seen.
  - start while busy is ignored.
- Skid FIFO:
  - Circular, FIFO_DEPTH entries, pointers wrap modulo the depth.
  - Simultaneous push and pop when full is allowed: in_ready is computed as !full || pop_this_cycle.
  - Pop occurs when pipeline stage 1 is free or advancing.
- Pipeline:
  - S1 registers a, b, y and the expected value exp = zero-extended a + zero-extended b (W+1 bits, no overflow loss).
  - S2 registers match = (y == exp) and updates the counters.
  - Latency from transfer to counter update is 3 cycles with an empty FIFO: FIFO write, S1, S2.
- Counting rules:
  - pass_cnt and fail_cnt saturate at all-ones; no wrap.
  - err sets on the first mismatch and stays set.
  - first_fail is written only when fail_cnt==0 before the increment.
- Handshake rule: in_a, in_b and in_y are sampled only on transfer; their values are don't-care otherwise.
- busy=1 in RUN and DRAIN only.
- Invariant: pass_cnt+fail_cnt == num_txn at done (absent saturation).

Decomposition:
- Package adder_chk_pkg holds:
  - state enum typedef chk_state_t {IDLE, RUN, DRAIN, DONE};
  - packed struct txn_t {a, b, y};
  - the localparam for the result width.
- One sub-module, chk_skid_fifo: parameterised circular FIFO carrying txn_t with full/empty outputs.
- The FSM, pipeline and counters stay in the top module.

Test Plan:
- Reset then start, num_txn=3, correct sums (3+4=7, 15+15=30, 0+0=0) -> done 6 cycles after the last transfer at the latest; pass_cnt=3, fail_cnt=0, err=0, first_fail=0.
- num_txn=4; 2nd txn a=5, b=6, y=10 (expected 11); 4th txn a=1, b=1, y=0 -> fail_cnt=2, pass_cnt=2, err=1, first_fail={4'h5, 4'h6, 5'h0A}.
- in_valid held high with the consumer path idle long enough to fill the FIFO -> in_ready deasserts after 4 accepted transactions with no loss; all 15 random transactions checked, pass_cnt=15.
- start with num_txn=0 -> done=1 the next cycle, counters 0, in_ready never high.
- rst_n=0 for 1 cycle after 2 of 5 transactions -> all outputs zero; a subsequent start with num_txn=2 completes with pass_cnt=2.
- CNT_W=2, num_txn=3 with all mismatches, then a second run of 3 passes -> fail_cnt=3 (saturated, no wrap); on restart counters clear, then pass_cnt=3, err=0.
